// File: rtl/mask_window_gen_if.sv
// rtl/mask_window_gen_if.sv - pixel-in / window-out bundle for mask_window_gen
//
// Signals:
//   pix_valid, pix_ready, pix_sof, pix_data      raster-order mask pixel stream
//   win, win_valid, win_x, win_y, frame_done     registered window output
// Modports:
//   master : upstream side (drives pixels, observes windows)
//   slave  : mask_window_gen side
interface mask_window_gen_if #(
    parameter int N_SIZE     = 5,
    parameter int COLORS     = 1,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic                                         pix_valid;
    logic                                         pix_ready;
    logic                                         pix_sof;
    logic [COLORS-1:0]                            pix_data;
    logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0]    win;
    logic                                         win_valid;
    logic [XW-1:0]                                win_x;
    logic [YW-1:0]                                win_y;
    logic                                         frame_done;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  pix_ready, win, win_valid, win_x, win_y, frame_done
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output pix_ready, win, win_valid, win_x, win_y, frame_done
    );
endinterface

// File: rtl/mask_window_gen.sv
// rtl/mask_window_gen.sv - streaming N_SIZE x N_SIZE colour-mask window generator
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        mask_window_gen_if.slave: pixel stream in, window stream out
//              win[i][j] = pixel (win_x+j-C, win_y+i-C), out-of-frame taps 0
//   frame_cnt  completed frames, wrapping      (MASK_WINDOW_STATUS_EN only)
//   abort_cnt  mid-frame sof aborts, saturating (MASK_WINDOW_STATUS_EN only)
//
// Optional feature macro: MASK_WINDOW_STATUS_EN
module mask_window_gen #(
    parameter int N_SIZE     = 5,
    parameter int COLORS     = 1,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    mask_window_gen_if.slave    bus
`ifdef MASK_WINDOW_STATUS_EN
    ,
    output logic [15:0]         frame_cnt,
    output logic [7:0]          abort_cnt
`endif
);
    localparam int C    = N_SIZE / 2;
    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT);
    // Pushes needed before the first centre is complete; also the flush length.
    localparam int LEAD = C * IMG_WIDTH + C;
    localparam int LW   = $clog2(LEAD + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [LW-1:0] LEAD_V  = LW'(LEAD);
    localparam logic [LW-1:0] FL_LAST = LW'(LEAD - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] win_t;

    state_t             state, state_n;
    logic               pix_ready;
    logic               start;
    logic               push;
    logic               emit;
    logic               lead_done;

    logic [XW-1:0]      px;
    logic [YW-1:0]      py;
    logic [LW-1:0]      lead_cnt;
    logic [LW-1:0]      fl_cnt;
    logic [XW-1:0]      cen_x;
    logic [YW-1:0]      cen_y;

    logic [XW-1:0]      wr_x;
    logic [COLORS-1:0]  push_data;
    logic [COLORS-1:0]  col [0:N_SIZE-1];

    // Line buffers hold the previous N_SIZE-1 lines, lb[0] being the newest.
    logic [COLORS-1:0]  lb [0:N_SIZE-2][0:IMG_WIDTH-1];
    win_t               sr;
    win_t               nsr;
    win_t               win_n;
    logic [N_SIZE-1:0]  row_ok;
    logic [N_SIZE-1:0]  col_ok;

    win_t               win_r;
    logic               win_valid_r;
    logic               frame_done_r;
    logic [XW-1:0]      win_x_r;
    logic [YW-1:0]      win_y_r;

    assign bus.pix_ready  = pix_ready;
    assign bus.win        = win_r;
    assign bus.win_valid  = win_valid_r;
    assign bus.win_x      = win_x_r;
    assign bus.win_y      = win_y_r;
    assign bus.frame_done = frame_done_r;

    assign lead_done = (lead_cnt == LEAD_V);
    // A restart pixel is always (0,0) and never completes a window of the old frame.
    assign emit      = push && !start && lead_done;
    assign wr_x      = start ? '0 : px;
    assign push_data = (state == FLUSH) ? '0 : bus.pix_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // pix_ready is 1 in IDLE and RUN, so pix_valid alone means accept there.
    always_comb begin
        state_n   = state;
        pix_ready = 1'b1;
        start     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pix_valid && bus.pix_sof) begin
                    start   = 1'b1;
                    push    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.pix_valid) begin
                    push = 1'b1;
                    if (bus.pix_sof) begin
                        start = 1'b1;
                    end else if (px == X_LAST && py == Y_LAST) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                pix_ready = 1'b0;
                push      = 1'b1;
                if (fl_cnt == FL_LAST) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Column entering the window: oldest line at row 0, the pushed pixel at row N_SIZE-1.
    always_comb begin
        for (int i = 0; i < N_SIZE - 1; i++) begin
            col[i] = lb[N_SIZE-2-i][wr_x];
        end
        col[N_SIZE-1] = push_data;
    end

    always_comb begin
        nsr = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE - 1; j++) begin
                nsr[i][j] = sr[i][j+1];
            end
            nsr[i][N_SIZE-1] = col[i];
        end
    end

    // The shift window is addressed linearly, so taps that wrap into the
    // neighbouring line or fall before/after the frame hold foreign or stale
    // data; the centre coordinates decide which taps are genuine.
    always_comb begin
        row_ok = '0;
        col_ok = '0;
        win_n  = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            row_ok[i] = (int'(cen_y) + i - C >= 0) && (int'(cen_y) + i - C < IMG_HEIGHT);
            col_ok[i] = (int'(cen_x) + i - C >= 0) && (int'(cen_x) + i - C < IMG_WIDTH);
        end
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE; j++) begin
                win_n[i][j] = (row_ok[i] && col_ok[j]) ? nsr[i][j] : '0;
            end
        end
    end

    // Datapath storage needs no reset: border masking hides its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            lb[0][wr_x] <= push_data;
            for (int k = 1; k < N_SIZE - 1; k++) begin
                lb[k][wr_x] <= lb[k-1][wr_x];
            end
            sr <= nsr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px       <= '0;
            py       <= '0;
            lead_cnt <= '0;
            fl_cnt   <= '0;
            cen_x    <= '0;
            cen_y    <= '0;
        end else begin
            if (start) begin
                px       <= XW'(1);
                py       <= '0;
                lead_cnt <= LW'(1);
                cen_x    <= '0;
                cen_y    <= '0;
            end else if (push) begin
                if (px == X_LAST) begin
                    px <= '0;
                    if (state == RUN && py != Y_LAST) begin
                        py <= py + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end
                if (!lead_done) begin
                    lead_cnt <= lead_cnt + 1'b1;
                end
                if (emit) begin
                    if (cen_x == X_LAST) begin
                        cen_x <= '0;
                        if (cen_y != Y_LAST) begin
                            cen_y <= cen_y + 1'b1;
                        end
                    end else begin
                        cen_x <= cen_x + 1'b1;
                    end
                end
            end
            fl_cnt <= (state == FLUSH) ? fl_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r        <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            win_x_r      <= '0;
            win_y_r      <= '0;
        end else begin
            win_valid_r  <= emit;
            frame_done_r <= emit && cen_x == X_LAST && cen_y == Y_LAST;
            if (emit) begin
                win_r   <= win_n;
                win_x_r <= cen_x;
                win_y_r <= cen_y;
            end
        end
    end

`ifdef MASK_WINDOW_STATUS_EN
    logic abort;

    assign abort = start && (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (frame_done_r) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (abort && abort_cnt != 8'hFF) begin
                abort_cnt <= abort_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mask_window_gen.sv
// tb/tb_mask_window_gen.sv - directed self-checking bench for mask_window_gen
module tb_mask_window_gen;
    localparam int N      = 3;
    localparam int COLORS = 1;
    localparam int W      = 8;
    localparam int H      = 6;
    localparam int C      = N / 2;
    localparam int NB     = N * N * COLORS;

    typedef struct {
        int              x;
        int              y;
        logic [NB-1:0]   w;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mask_window_gen_if #(.N_SIZE(N), .COLORS(COLORS), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

`ifdef MASK_WINDOW_STATUS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  abort_cnt;
`endif

    mask_window_gen #(.N_SIZE(N), .COLORS(COLORS), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MASK_WINDOW_STATUS_EN
        .frame_cnt (frame_cnt),
        .abort_cnt (abort_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    rec_t              cap[$];
    rec_t              mon_r;
    int                fd_cnt  = 0;
    int                fd_x    = -1;
    int                fd_y    = -1;
    int                fd_wv   = 0;
    int                rdy_low = 0;

    always @(negedge clk) begin
        if (bus.win_valid) begin
            mon_r.x = int'(bus.win_x);
            mon_r.y = int'(bus.win_y);
            mon_r.w = bus.win;
            cap.push_back(mon_r);
        end
        if (bus.frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_x   = int'(bus.win_x);
            fd_y   = int'(bus.win_y);
            fd_wv  = int'(bus.win_valid);
        end
        if (!bus.pix_ready) begin
            rdy_low = rdy_low + 1;
        end
    end

    int                checks = 0;
    int                errors = 0;
    logic [COLORS-1:0] img [0:H-1][0:W-1];
    rec_t              ref_q[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t rec_at(int k);
        rec_t r;
        r.x = -1;
        r.y = -1;
        r.w = '0;
        if (k >= 0 && k < cap.size()) r = cap[k];
        return r;
    endfunction

    function automatic logic [NB-1:0] exp_win(int cx, int cy);
        logic [0:N-1][0:N-1][COLORS-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int r, c;
                r = cy + i - C;
                c = cx + j - C;
                if (r >= 0 && r < H && c >= 0 && c < W) e[i][j] = img[r][c];
            end
        end
        return e;
    endfunction

    function automatic int frame_bad(int base);
        int   bad;
        rec_t r;
        bad = 0;
        for (int k = 0; k < W * H; k++) begin
            r = rec_at(base + k);
            if (r.x != k % W || r.y != k / W || r.w !== exp_win(k % W, k / W)) bad++;
        end
        return bad;
    endfunction

    task automatic fill(input logic [COLORS-1:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = v;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input logic [COLORS-1:0] d, input logic sof, input bit bubble);
        logic rdy;
        int   n;
        if (bubble) begin
            n = 0;
            while (n < 4 && $urandom_range(0, 1) == 1) begin
                bus.pix_valid = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
        end
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_data  = d;
        n = 0;
        forever begin
            rdy = bus.pix_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 100) begin
                chk("push_timeout", 64'(rdy), 64'd1);
                break;
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit bubble);
        for (int k = 0; k < W * H; k++) begin
            push_pix(img[k / W][k % W], k == 0, bubble);
        end
    endtask

    initial begin
        int   base, fd0, rl0, hits, first, diffs;
        rec_t r;

        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
        rst_n         = 1'b0;
        settle(3);

        chk("rst_pix_ready", 64'(bus.pix_ready), 64'd1);
        chk("rst_win_valid", 64'(bus.win_valid), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_win", 64'(bus.win), 64'd0);
        chk("rst_win_x", 64'(bus.win_x), 64'd0);
        chk("rst_win_y", 64'(bus.win_y), 64'd0);
        rst_n = 1'b1;
        settle(1);

        // All-ones frame, gap-free
        fill('1);
        base = cap.size();
        fd0  = fd_cnt;
        rl0  = rdy_low;
        send_frame(0);
        settle(15);
        chk("ones_count", 64'(cap.size() - base), 64'd48);
        r = rec_at(base);
        chk("ones_c00_xy", 64'({r.x[7:0], r.y[7:0]}), 64'h0000);
        chk("ones_c00_win", 64'(r.w), 64'(9'b000_011_011));
        r = rec_at(base + 19);
        chk("ones_c32_xy", 64'({r.x[7:0], r.y[7:0]}), 64'h0302);
        chk("ones_c32_win", 64'(r.w), 64'(9'b111_111_111));
        r = rec_at(base + 47);
        chk("ones_c75_xy", 64'({r.x[7:0], r.y[7:0]}), 64'h0705);
        chk("ones_c75_win", 64'(r.w), 64'(9'b110_110_000));
        chk("ones_frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
        chk("ones_frame_done_at", 64'({fd_x[7:0], fd_y[7:0]}), 64'h0705);
        chk("ones_frame_done_wv", 64'(fd_wv), 64'd1);
        chk("ones_ready_low", 64'(rdy_low - rl0), 64'd9);
        chk("ones_model", 64'(frame_bad(base)), 64'd0);

        // Single 1 at (4,3)
        fill('0);
        img[3][4] = 1'b1;
        base = cap.size();
        send_frame(0);
        settle(15);
        hits  = 0;
        first = -1;
        for (int k = 0; k < 48; k++) begin
            r = rec_at(base + k);
            if (r.w != '0) begin
                hits++;
                if (first < 0) first = k;
            end
        end
        chk("dot_hits", 64'(hits), 64'd9);
        r = rec_at(base + first);
        chk("dot_first_xy", 64'({r.x[7:0], r.y[7:0]}), 64'h0302);
        chk("dot_first_win", 64'(r.w), 64'(9'b000_000_001));
        chk("dot_model", 64'(frame_bad(base)), 64'd0);

        // Random image: gap-free, then with input bubbles
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = COLORS'($urandom_range(0, 1));
        base = cap.size();
        send_frame(0);
        settle(15);
        chk("rand_model", 64'(frame_bad(base)), 64'd0);
        ref_q.delete();
        for (int k = 0; k < 48; k++) ref_q.push_back(rec_at(base + k));
        base = cap.size();
        send_frame(1);
        settle(15);
        chk("bubble_count", 64'(cap.size() - base), 64'd48);
        diffs = 0;
        for (int k = 0; k < 48; k++) begin
            r = rec_at(base + k);
            if (r.x != ref_q[k].x || r.y != ref_q[k].y || r.w !== ref_q[k].w) diffs++;
        end
        chk("bubble_vs_gapfree", 64'(diffs), 64'd0);

        // Mid-frame abort: 20 pixels of ones, then sof starts an all-zero frame
        fill('1);
        base = cap.size();
        fd0  = fd_cnt;
        for (int k = 0; k < 20; k++) push_pix(1'b1, k == 0, 0);
        fill('0);
        send_frame(0);
        settle(15);
        chk("abort_count", 64'(cap.size() - base), 64'd59);
        chk("abort_frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
        chk("abort_frame_done_at", 64'({fd_x[7:0], fd_y[7:0]}), 64'h0705);
        hits = 0;
        for (int k = 11; k < 59; k++) begin
            r = rec_at(base + k);
            if (r.w != '0) hits++;
        end
        chk("abort_stale_ones", 64'(hits), 64'd0);
        chk("abort_model", 64'(frame_bad(base + 11)), 64'd0);
`ifdef MASK_WINDOW_STATUS_EN
        chk("abort_cnt", 64'(abort_cnt), 64'd1);
        chk("frame_cnt", 64'(frame_cnt), 64'd5);
`endif

        // Reset during FLUSH
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = COLORS'((x + y) & 1);
        send_frame(0);
        settle(3);
        chk("flush_ready_low", 64'(bus.pix_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("flushrst_pix_ready", 64'(bus.pix_ready), 64'd1);
        chk("flushrst_win_valid", 64'(bus.win_valid), 64'd0);
        chk("flushrst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("flushrst_win", 64'(bus.win), 64'd0);
        chk("flushrst_win_xy", 64'({bus.win_x, bus.win_y}), 64'd0);
`ifdef MASK_WINDOW_STATUS_EN
        chk("flushrst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("flushrst_abort_cnt", 64'(abort_cnt), 64'd0);
`endif
        settle(2);
        rst_n = 1'b1;
        settle(1);
        base = cap.size();
        send_frame(0);
        settle(15);
        chk("postrst_count", 64'(cap.size() - base), 64'd48);
        chk("postrst_model", 64'(frame_bad(base)), 64'd0);

        // Pixels without sof in IDLE are discarded
        base = cap.size();
        for (int k = 0; k < 5; k++) push_pix(1'b1, 1'b0, 0);
        settle(12);
        chk("idle_nosof_windows", 64'(cap.size() - base), 64'd0);
        fill('0);
        img[0][0] = 1'b1;
        base = cap.size();
        send_frame(0);
        settle(15);
        r = rec_at(base);
        chk("idle_sof_first_xy", 64'({r.x[7:0], r.y[7:0]}), 64'h0000);
        chk("idle_sof_first_win", 64'(r.w), 64'(9'b000_010_000));
        chk("idle_sof_count", 64'(cap.size() - base), 64'd48);
        chk("idle_sof_model", 64'(frame_bad(base)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mask_window_gen.md
Name: mask_window_gen

Overview:
- Streaming window generator placed directly upstream of the neighbourhood denoiser.
- Accepts raster-order per-pixel colour-mask bits from the colour classifier.
- Buffers N_SIZE-1 image lines internally.
- For every pixel of the frame, emits the N_SIZE x N_SIZE neighbourhood centred on that pixel, in the same array layout the denoiser consumes. Out-of-frame taps are forced to zero.

Parameters:
- N_SIZE, 5, window edge length; must be odd and >= 3; C = N_SIZE/2.
- COLORS, 1, mask bits per pixel.
- IMG_WIDTH, 640, pixels per line; must be >= N_SIZE.
- IMG_HEIGHT, 480, lines per frame; must be >= N_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  block can accept a pixel.
- pix_sof  in  1  qualifies pixel (0,0) of a frame; sampled only on accept.
- pix_data  in  COLORS  mask bits of the current pixel.
- win  out  [COLORS-1:0] x [0:N_SIZE-1][0:N_SIZE-1]  window; win[i][j] = pixel (cx+j-C, cy+i-C).
- win_valid  out  1  one-cycle strobe, win/win_x/win_y valid.
- win_x  out  $clog2(IMG_WIDTH)  centre column cx.
- win_y  out  $clog2(IMG_HEIGHT)  centre row cy.
- frame_done  out  1  one-cycle strobe with the last window of a frame.

Behaviour:
- Reset: FSM=IDLE; pix_ready=1; win_valid=0; frame_done=0; win all 0; win_x=win_y=0; counters 0. Line buffer contents are don't-care (masked by border logic).
- Accept = pix_valid & pix_ready.
- Linear index: L = y*IMG_WIDTH + x of the pushed pixel (accepted or injected). Centre index = L - (C*IMG_WIDTH + C).
- The window is emitted when 0 <= centre index <= IMG_WIDTH*IMG_HEIGHT-1.
- Output registered: win_valid rises 1 cycle after the push that completes the window.
- No output backpressure.
- Border masking: any tap with column outside 0..IMG_WIDTH-1 or row outside 0..IMG_HEIGHT-1 is 0. This includes horizontal taps that would wrap into the adjacent line.
- FSM:
  - IDLE: accepted pixel with pix_sof=1 is pushed as (0,0), goto RUN. Accepted pixels without sof are discarded.
  - RUN: push each accepted pixel, advance x, wrap at IMG_WIDTH-1 to next y. Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) goes to FLUSH.
  - FLUSH: pix_ready=0. Inject C*IMG_WIDTH + C zero pixels, one per cycle. After the last injection, goto IDLE.
  - frame_done pulses with win_valid for centre (IMG_WIDTH-1, IMG_HEIGHT-1).
- Exactly IMG_WIDTH*IMG_HEIGHT windows per frame, raster order. No gaps other than input bubbles.
- pix_sof accepted in RUN (mid-frame): abort the current frame. Emit no further windows for it and no frame_done. The pixel becomes (0,0) of the new frame. Border masking guarantees stale data never reaches win.
- pix_sof=1 on a pixel whose coordinates are not (0,0) while in IDLE is the normal start; pix_sof is ignored during FLUSH because pix_ready=0.
- rst_n asserted mid-frame or mid-flush: immediate return to reset values; partial frame discarded.
- Throughput: 1 pixel/cycle in RUN. Frame overhead: C*IMG_WIDTH + C cycles of FLUSH.

Optional Feature:
- Macro: MASK_WINDOW_STATUS_EN.
- Defined: adds output ports frame_cnt[15:0] and abort_cnt[7:0], both reset to 0.
  - frame_cnt increments on each frame_done and wraps at 16'hFFFF->0.
  - abort_cnt increments on each mid-frame sof abort and saturates at 8'hFF.
- Undefined: ports absent; no counter logic.

Test Plan (N_SIZE=3, COLORS=1, IMG_WIDTH=8, IMG_HEIGHT=6):
- Reset then all-ones frame at 1 pixel/cycle:
  - 48 win_valid strobes.
  - Centre (0,0): win = {000,011,011}.
  - Centre (3,2): all 9 ones.
  - Centre (7,5): {110,110,000}.
  - frame_done once, coincident with (7,5); pix_ready low for exactly 9 cycles.
- Single 1 at (4,3), rest 0:
  - win[i][j]=1 only for centres (4-j+1, 3-i+1), i.e. exactly 9 windows contain a 1.
  - First such window is centre (3,2) with win[2][2]=1.
- Random pix_valid bubbles (~50%):
  - Same 48 windows, same order and values as the gap-free run.
  - win_valid never asserted in a cycle without a preceding push.
- Mid-frame abort: sof at pixel 20, then a full all-zeros frame:
  - No frame_done for the first frame.
  - Next 48 windows all zero, with no stale ones.
  - abort_cnt=1 when the macro is defined.
- rst_n pulsed low during FLUSH:
  - Outputs return to reset values the same cycle.
  - pix_ready=1.
  - A following full frame produces a correct 48 windows.
- Pixels without sof while in IDLE:
  - Discarded, zero win_valid.
  - The next sof starts at (0,0).
